array_multiplier_4bit: RTL and testbench

- Unsigned 4x4-bit array multiplier built from an AND-gate partial-product plane and a ripple array of half/full adder cells.
- Provides the 8-bit product combinationally on z.
- Also provides a registered copy of the product on z_q for pipelined datapaths.
- Sits in the arithmetic datapath as a leaf block; it has no handshake.

---
 rtl/array_multiplier_4bit.sv | 77 +++++++
 tb/tb_array_multiplier_4bit.sv | 135 +++++++++++++
 2 files changed

// File: rtl/array_multiplier_4bit.sv
// Unsigned 4x4 array multiplier: AND partial-product plane plus a 12-cell ripple
// adder array, with a combinational product and a registered copy.

module half_adder (
    input  logic i_a,
    input  logic i_b,
    output logic o_s,
    output logic o_c
);
    assign o_s = i_a ^ i_b;
    assign o_c = i_a & i_b;
endmodule

module full_adder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_ci,
    output logic o_s,
    output logic o_co
);
    assign o_s  = i_a ^ i_b ^ i_ci;
    assign o_co = (i_a & i_b) | (i_ci & (i_a ^ i_b));
endmodule

module array_multiplier_4bit (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] z,
    output logic [7:0] z_q
);
    logic [3:0] w_pp [4];
    logic [3:0] w_s1;
    logic [3:0] w_c1;
    logic [3:0] w_s2;
    logic [3:0] w_c2;
    logic [3:0] w_s3;
    logic [3:0] w_c3;
    logic [7:0] r_z_q;

    always_comb begin
        for (int unsigned i = 0; i < 4; i++) begin
            w_pp[i] = a & {4{b[i]}};
        end
    end

    // Row 1: columns 1..4; carry out of column 4 (w_c1[3]) has weight 5.
    half_adder u_r1_c0 (.i_a(w_pp[0][1]), .i_b(w_pp[1][0]),                   .o_s(w_s1[0]), .o_c(w_c1[0]));
    full_adder u_r1_c1 (.i_a(w_pp[0][2]), .i_b(w_pp[1][1]), .i_ci(w_c1[0]),   .o_s(w_s1[1]), .o_co(w_c1[1]));
    full_adder u_r1_c2 (.i_a(w_pp[0][3]), .i_b(w_pp[1][2]), .i_ci(w_c1[1]),   .o_s(w_s1[2]), .o_co(w_c1[2]));
    half_adder u_r1_c3 (.i_a(w_pp[1][3]), .i_b(w_c1[2]),                      .o_s(w_s1[3]), .o_c(w_c1[3]));

    // Row 2: columns 2..5, row-1 carry out enters as the top-column operand.
    half_adder u_r2_c0 (.i_a(w_s1[1]),    .i_b(w_pp[2][0]),                   .o_s(w_s2[0]), .o_c(w_c2[0]));
    full_adder u_r2_c1 (.i_a(w_s1[2]),    .i_b(w_pp[2][1]), .i_ci(w_c2[0]),   .o_s(w_s2[1]), .o_co(w_c2[1]));
    full_adder u_r2_c2 (.i_a(w_s1[3]),    .i_b(w_pp[2][2]), .i_ci(w_c2[1]),   .o_s(w_s2[2]), .o_co(w_c2[2]));
    full_adder u_r2_c3 (.i_a(w_c1[3]),    .i_b(w_pp[2][3]), .i_ci(w_c2[2]),   .o_s(w_s2[3]), .o_co(w_c2[3]));

    // Row 3: columns 3..6, final carry is z[7].
    half_adder u_r3_c0 (.i_a(w_s2[1]),    .i_b(w_pp[3][0]),                   .o_s(w_s3[0]), .o_c(w_c3[0]));
    full_adder u_r3_c1 (.i_a(w_s2[2]),    .i_b(w_pp[3][1]), .i_ci(w_c3[0]),   .o_s(w_s3[1]), .o_co(w_c3[1]));
    full_adder u_r3_c2 (.i_a(w_s2[3]),    .i_b(w_pp[3][2]), .i_ci(w_c3[1]),   .o_s(w_s3[2]), .o_co(w_c3[2]));
    full_adder u_r3_c3 (.i_a(w_c2[3]),    .i_b(w_pp[3][3]), .i_ci(w_c3[2]),   .o_s(w_s3[3]), .o_co(w_c3[3]));

    assign z = {w_c3[3], w_s3, w_s2[0], w_s1[0], w_pp[0][0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_z_q <= '0;
        end else begin
            r_z_q <= z;
        end
    end

    assign z_q = r_z_q;
endmodule

// File: tb/tb_array_multiplier_4bit.sv
// Directed self-checking bench for array_multiplier_4bit: exhaustive combinational
// sweep, corner products, and registered-output reset/latency behaviour.

module tb_array_multiplier_4bit;
    logic       clk;
    logic       rst;
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] z;
    logic [7:0] z_q;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    array_multiplier_4bit dut (
        .clk (clk),
        .rst (rst),
        .a   (a),
        .b   (b),
        .z   (z),
        .z_q (z_q)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d (0x%h) expected %0d (0x%h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic apply_comb(input logic [3:0] ai, input logic [3:0] bi,
                              input logic [7:0] exp, input string tag);
        a = ai;
        b = bi;
        #1;
        check(tag, z, exp);
        #4;
    endtask

    initial begin
        logic [7:0] exp_p;
        rst = 1'b1;
        a   = '0;
        b   = '0;

        // Exhaustive combinational sweep
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                a = 4'(ia);
                b = 4'(ib);
                exp_p = 8'(ia * ib);
                #1;
                check($sformatf("sweep a=%0d b=%0d", ia, ib), z, exp_p);
                #4;
            end
        end

        // Corners and carry-chain stress
        apply_comb(4'd3,  4'd5,  8'd15,  "a3_b5");
        apply_comb(4'd9,  4'd7,  8'd63,  "a9_b7");
        apply_comb(4'd0,  4'd15, 8'd0,   "a0_b15");
        apply_comb(4'd15, 4'd1,  8'd15,  "a15_b1");
        apply_comb(4'd15, 4'd15, 8'hE1,  "a15_b15");
        apply_comb(4'd8,  4'd8,  8'h40,  "a8_b8");
        apply_comb(4'd15, 4'd14, 8'hD2,  "a15_b14");
        apply_comb(4'd14, 4'd15, 8'hD2,  "a14_b15");
        apply_comb(4'd13, 4'd11, 8'h8F,  "a13_b11");

        // Reset held for two edges with max operands
        @(negedge clk);
        rst = 1'b1;
        a   = 4'd15;
        b   = 4'd15;
        @(posedge clk); #1;
        check("rst_edge1_zq", z_q, 8'h00);
        check("rst_edge1_z",  z,   8'd225);
        @(posedge clk); #1;
        check("rst_edge2_zq", z_q, 8'h00);
        rst = 1'b0;
        @(posedge clk); #1;
        check("rst_release_zq", z_q, 8'd225);

        // Pipeline latency: one new product per edge
        a = 4'd6;
        b = 4'd7;
        @(posedge clk); #1;
        check("pipe_n_zq", z_q, 8'd42);
        a = 4'd12;
        b = 4'd11;
        #1;
        check("pipe_hold_zq", z_q, 8'd42);
        check("pipe_comb_z",  z,   8'd132);
        @(posedge clk); #1;
        check("pipe_n1_zq", z_q, 8'd132);

        // Reset mid-stream overrides capture on that edge
        a = 4'd6;
        b = 4'd7;
        @(posedge clk); #1;
        check("mid_pre_zq", z_q, 8'd42);
        rst = 1'b1;
        a   = 4'd12;
        b   = 4'd11;
        @(posedge clk); #1;
        check("mid_rst_zq", z_q, 8'h00);
        check("mid_rst_z",  z,   8'd132);
        rst = 1'b0;
        @(posedge clk); #1;
        check("mid_release_zq", z_q, 8'd132);

        // z_q holds between edges while inputs change
        a = 4'd1;
        b = 4'd1;
        #2;
        check("hold_zq", z_q, 8'd132);
        check("hold_z",  z,   8'd1);
        @(posedge clk); #1;
        check("hold_next_zq", z_q, 8'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
